// File: rtl/trace_pkg.sv
// Shared trace-entry definitions used by the commit trace buffer and its storage.
// Entries are packed {pc, wen, waddr, wdata}, with pc in the most significant bits.
package trace_pkg;

  localparam int TRACE_PC_W    = 32;
  localparam int TRACE_WEN_W   = 4;
  localparam int TRACE_WADDR_W = 5;
  localparam int TRACE_DATA_W  = 32;
  localparam int TRACE_ENTRY_W = TRACE_PC_W + TRACE_WEN_W + TRACE_WADDR_W + TRACE_DATA_W;

  localparam int TRACE_WDATA_LSB = 0;
  localparam int TRACE_WADDR_LSB = TRACE_WDATA_LSB + TRACE_DATA_W;
  localparam int TRACE_WEN_LSB   = TRACE_WADDR_LSB + TRACE_WADDR_W;
  localparam int TRACE_PC_LSB    = TRACE_WEN_LSB + TRACE_WEN_W;

  typedef struct packed {
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_WEN_W-1:0]   wen;
    logic [TRACE_WADDR_W-1:0] waddr;
    logic [TRACE_DATA_W-1:0]  wdata;
  } trace_entry_t;

  function automatic logic [TRACE_ENTRY_W-1:0] pack_entry(
    input logic [TRACE_PC_W-1:0]    pc,
    input logic [TRACE_WEN_W-1:0]   wen,
    input logic [TRACE_WADDR_W-1:0] waddr,
    input logic [TRACE_DATA_W-1:0]  wdata
  );
    return {pc, wen, waddr, wdata};
  endfunction

  function automatic trace_entry_t unpack_entry(input logic [TRACE_ENTRY_W-1:0] raw);
    trace_entry_t e;
    e.pc    = raw[TRACE_PC_LSB    +: TRACE_PC_W];
    e.wen   = raw[TRACE_WEN_LSB   +: TRACE_WEN_W];
    e.waddr = raw[TRACE_WADDR_LSB +: TRACE_WADDR_W];
    e.wdata = raw[TRACE_WDATA_LSB +: TRACE_DATA_W];
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x TRACE_ENTRY_W register array: one synchronous write port and one
// asynchronous read port that presents the FIFO head.
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [TRACE_ENTRY_W-1:0]   wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [TRACE_ENTRY_W-1:0]   rdata
);

  logic [TRACE_ENTRY_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers and level,
  // so stale words are never presented and the array maps onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures register-file commits into a first-word-fall-through FIFO and streams
// them out on valid/ready; a full FIFO drops commits instead of stalling the core.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter bit SKIP_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic [TRACE_PC_W-1:0]    debug_pc_addr,
  input  logic [TRACE_WEN_W-1:0]   debug_reg_write_en,
  input  logic [TRACE_WADDR_W-1:0] debug_reg_write_addr,
  input  logic [TRACE_DATA_W-1:0]  debug_reg_write_data,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [TRACE_PC_W-1:0]    trace_pc,
  output logic [TRACE_WEN_W-1:0]   trace_wen,
  output logic [TRACE_WADDR_W-1:0] trace_waddr,
  output logic [TRACE_DATA_W-1:0]  trace_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [31:0]              commit_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [TRACE_ENTRY_W-1:0] head_raw;
  trace_entry_t             head;
  logic                     empty, full, commit_evt, pop, push, drop;

  assign empty = (level == '0);
  assign full  = (level == FULL_LEVEL);

  assign commit_evt = capture_en && (|debug_reg_write_en) &&
                      !(SKIP_R0 && (debug_reg_write_addr == '0));
  assign pop  = !empty && trace_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign push = commit_evt && (!full || pop);
  assign drop = commit_evt && full && !pop;

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push && !clear),
    .waddr (wr_ptr),
    .wdata (pack_entry(debug_pc_addr, debug_reg_write_en,
                       debug_reg_write_addr, debug_reg_write_data)),
    .raddr (rd_ptr),
    .rdata (head_raw)
  );

  assign head        = unpack_entry(head_raw);
  assign trace_valid = !empty;
  assign trace_pc    = head.pc;
  assign trace_wen   = head.wen;
  assign trace_waddr = head.waddr;
  assign trace_wdata = head.wdata;

  // NOTE: all state updates use non-blocking assignments so every branch below
  // sees the pre-edge values of pointers, level and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      commit_count <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      commit_count <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        commit_count <= commit_count + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int DEPTH    = 16;
  localparam int CNT_W    = 3;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              capture_en, clear, trace_ready;
  logic [31:0]       debug_pc_addr, debug_reg_write_data;
  logic [3:0]        debug_reg_write_en;
  logic [4:0]        debug_reg_write_addr;
  logic              trace_valid;
  logic [31:0]       trace_pc, trace_wdata;
  logic [3:0]        trace_wen;
  logic [4:0]        trace_waddr;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic [31:0]       commit_count;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SKIP_R0(1'b1)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .capture_en           (capture_en),
    .clear                (clear),
    .debug_pc_addr        (debug_pc_addr),
    .debug_reg_write_en   (debug_reg_write_en),
    .debug_reg_write_addr (debug_reg_write_addr),
    .debug_reg_write_data (debug_reg_write_data),
    .trace_valid          (trace_valid),
    .trace_ready          (trace_ready),
    .trace_pc             (trace_pc),
    .trace_wen            (trace_wen),
    .trace_waddr          (trace_waddr),
    .trace_wdata          (trace_wdata),
    .level                (level),
    .overflow             (overflow),
    .drop_count           (drop_count),
    .commit_count         (commit_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain queue of commits plus counters.
  typedef struct {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ent_t;

  ent_t        q[$];
  int          m_drops;
  logic [31:0] m_commits;
  bit          m_ovf;

  function automatic void model_reset();
    q.delete();
    m_drops   = 0;
    m_commits = 0;
    m_ovf     = 0;
  endfunction

  function automatic void model_step();
    bit   is_evt, do_pop, room;
    ent_t e;
    if (clear) begin
      model_reset();
      return;
    end
    is_evt = capture_en && (debug_reg_write_en != 0) && (debug_reg_write_addr != 0);
    do_pop = (q.size() > 0) && trace_ready;
    room   = (q.size() < DEPTH) || do_pop;
    if (do_pop) void'(q.pop_front());
    if (is_evt) begin
      if (room) begin
        e.pc = debug_pc_addr; e.wen = debug_reg_write_en;
        e.waddr = debug_reg_write_addr; e.wdata = debug_reg_write_data;
        q.push_back(e);
        m_commits = m_commits + 32'd1;
      end else begin
        m_ovf = 1;
        if (m_drops < DROP_MAX) m_drops++;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(trace_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, ".pc"},    64'(trace_pc),    64'(q[0].pc));
      check({tag, ".wen"},   64'(trace_wen),   64'(q[0].wen));
      check({tag, ".waddr"}, 64'(trace_waddr), 64'(q[0].waddr));
      check({tag, ".wdata"}, 64'(trace_wdata), 64'(q[0].wdata));
    end
    check({tag, ".level"},  64'(level),        64'(q.size()));
    check({tag, ".ovf"},    64'(overflow),     64'(m_ovf));
    check({tag, ".drops"},  64'(drop_count),   64'(m_drops));
    check({tag, ".commits"},64'(commit_count), 64'(m_commits));
  endtask

  task automatic set_in(input bit ce, input bit clr, input logic [31:0] pc,
                        input logic [3:0] wen, input logic [4:0] wa,
                        input logic [31:0] wd, input bit rdy);
    capture_en = ce; clear = clr; debug_pc_addr = pc; debug_reg_write_en = wen;
    debug_reg_write_addr = wa; debug_reg_write_data = wd; trace_ready = rdy;
  endtask

  task automatic idle(input bit rdy);
    set_in(1'b0, 1'b0, 32'h0, 4'h0, 5'h0, 32'h0, rdy);
  endtask

  // Inputs are driven after the falling edge; outputs are checked on the next falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_clear();
    set_in(1'b0, 1'b1, 32'h0, 4'h0, 5'h0, 32'h0, 1'b0);
    tick("clr");
  endtask

  task automatic commit_n(input int n, input bit rdy, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, 1'b0, base + 32'(i * 4), 4'(1 + i % 15), 5'(1 + i % 31),
             $urandom(), rdy);
      tick("cmt");
    end
  endtask

  int accepted_before;

  initial begin
    model_reset();
    rst = 1'b1;
    idle(1'b0);
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // 1: single commit with ready high; first-word-fall-through, latency 1
    set_in(1'b1, 1'b0, 32'hBFC0_0000, 4'hF, 5'd3, 32'h1234_5678, 1'b1);
    tick("t1");
    check("t1.valid", 64'(trace_valid), 64'd1);
    check("t1.pc", 64'(trace_pc), 64'hBFC0_0000);
    check("t1.wdata", 64'(trace_wdata), 64'h1234_5678);
    check("t1.commits", 64'(commit_count), 64'd1);
    idle(1'b1);
    tick("t1drain");

    // 2: filtered commits (r0 target, zero byte enables, capture disabled)
    do_clear();
    idle(1'b1);
    set_in(1'b1, 1'b0, 32'h100, 4'hF, 5'd0, 32'hDEAD_BEEF, 1'b1); tick("t2r0");
    set_in(1'b1, 1'b0, 32'h104, 4'h0, 5'd5, 32'hCAFE_F00D, 1'b1); tick("t2wen0");
    set_in(1'b0, 1'b0, 32'h108, 4'hF, 5'd5, 32'h0BAD_F00D, 1'b1); tick("t2dis");
    check("t2.valid", 64'(trace_valid), 64'd0);
    check("t2.commits", 64'(commit_count), 64'd0);

    // 3: 18 commits into a stalled consumer
    do_clear();
    commit_n(18, 1'b0, 32'h8000_0000);
    check("t3.level", 64'(level), 64'd16);
    check("t3.ovf", 64'(overflow), 64'd1);
    check("t3.drops", 64'(drop_count), 64'd2);

    // 4: full FIFO, pop and commit in the same cycle
    set_in(1'b1, 1'b0, 32'h9000_0000, 4'h3, 5'd7, 32'h7777_7777, 1'b1);
    tick("t4");
    check("t4.level", 64'(level), 64'd16);
    check("t4.drops", 64'(drop_count), 64'd2);

    // drop counter saturation with more stalled commits
    commit_n(8, 1'b0, 32'hA000_0000);
    check("sat.drops", 64'(drop_count), 64'(DROP_MAX));

    // drain in order
    idle(1'b1);
    for (int i = 0; i < DEPTH; i++) tick("drain");
    check("drain.valid", 64'(trace_valid), 64'd0);

    // 5: random traffic with random backpressure, kept below full
    do_clear();
    for (int cyc = 0; cyc < 3000 && m_commits < 100; cyc++) begin
      set_in((q.size() < DEPTH - 1) && ($urandom_range(0, 1) == 1), 1'b0, $urandom(),
             4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), $urandom(),
             $urandom_range(0, 1) == 1);
      tick("rand");
    end
    check("rand.done", 64'(m_commits >= 100), 64'd1);
    check("rand.ovf", 64'(overflow), 64'd0);
    idle(1'b1);
    for (int i = 0; i < DEPTH + 2; i++) tick("rdrain");

    // 6a: asynchronous reset mid-stream with a commit presented
    do_clear();
    commit_n(5, 1'b0, 32'hC000_0000);
    check("t6.level5", 64'(level), 64'd5);
    set_in(1'b1, 1'b0, 32'hC100_0000, 4'hF, 5'd9, 32'h5555_AAAA, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("t6rst.valid", 64'(trace_valid), 64'd0);
    check("t6rst.level", 64'(level), 64'd0);
    @(negedge clk);
    check_all("t6rst");
    rst = 1'b0;
    idle(1'b0);
    tick("t6post");

    // 6b: clear together with a commit and ready
    commit_n(5, 1'b0, 32'hD000_0000);
    accepted_before = int'(m_commits);
    check("t6b.pre", 64'(commit_count), 64'(accepted_before));
    set_in(1'b1, 1'b1, 32'hD100_0000, 4'hF, 5'd4, 32'h1111_2222, 1'b1);
    tick("t6clr");
    check("t6clr.valid", 64'(trace_valid), 64'd0);
    check("t6clr.level", 64'(level), 64'd0);
    check("t6clr.commits", 64'(commit_count), 64'd0);
    idle(1'b0);
    tick("t6clr2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
